// File: rtl/fma_arbiter.sv
// Round-robin arbiter feeding one pipelined fixed-point FMA,
// with a latency-matched tag pipe that steers results back.
module fma_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int FMA_LATENCY = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*32-1:0]             req_a,
  input  logic [NUM_REQ*32-1:0]             req_b,
  input  logic [NUM_REQ*32-1:0]             req_c,
  input  logic [NUM_REQ*2-1:0]              req_op,
  output logic                              fma_in_valid,
  output logic [31:0]                       fma_a,
  output logic [31:0]                       fma_b,
  output logic [31:0]                       fma_c,
  output logic [1:0]                        fma_op,
  input  logic                              fma_out_valid,
  input  logic [31:0]                       fma_r,
  output logic [NUM_REQ-1:0]                resp_valid,
  output logic [31:0]                       resp_r,
  output logic [$clog2(FMA_LATENCY+2)-1:0]  in_flight,
  output logic                              err
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(FMA_LATENCY+2);

  typedef struct packed {
    logic          v;
    logic [IW-1:0] id;
  } tag_t;

  logic [IW-1:0] ptr;
  logic [IW-1:0] gnt_id;
  logic [IW-1:0] iss_id;
  logic [IW:0]   cand;
  logic          hs;
  logic [31:0]   a_sel;
  logic [31:0]   b_sel;
  logic [31:0]   c_sel;
  logic [1:0]    op_sel;
  tag_t          tags [FMA_LATENCY];
  tag_t          tail;

  // first valid at or after ptr, wrapping; depends on ptr and req_valid only
  always_comb begin
    req_ready = '0;
    gnt_id    = '0;
    hs        = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_REQ))
        cand = cand - (IW+1)'(NUM_REQ);
      if (!hs && req_valid[cand[IW-1:0]]) begin
        hs                        = 1'b1;
        req_ready[cand[IW-1:0]]   = 1'b1;
        gnt_id                    = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    a_sel  = '0;
    b_sel  = '0;
    c_sel  = '0;
    op_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        a_sel  = req_a[32*i +: 32];
        b_sel  = req_b[32*i +: 32];
        c_sel  = req_c[32*i +: 32];
        op_sel = req_op[2*i +: 2];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr          <= '0;
      iss_id       <= '0;
      fma_in_valid <= 1'b0;
      fma_a        <= '0;
      fma_b        <= '0;
      fma_c        <= '0;
      fma_op       <= '0;
    end else begin
      fma_in_valid <= hs;
      if (hs) begin
        fma_a  <= a_sel;
        fma_b  <= b_sel;
        fma_c  <= c_sel;
        fma_op <= op_sel;
        iss_id <= gnt_id;
        ptr    <= (gnt_id == IW'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
      end
    end
  end

  // tag tail lines up with the FMA output of the same operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < FMA_LATENCY; k++)
        tags[k] <= '0;
    end else begin
      tags[0] <= '{v: fma_in_valid, id: iss_id};
      for (int k = 1; k < FMA_LATENCY; k++)
        tags[k] <= tags[k-1];
    end
  end

  assign tail   = tags[FMA_LATENCY-1];
  assign resp_r = fma_r;

  always_comb begin
    resp_valid = '0;
    if (fma_out_valid && tail.v)
      resp_valid[tail.id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight <= '0;
      err       <= 1'b0;
    end else begin
      in_flight <= in_flight + CW'(hs) - CW'(tail.v);
      if (fma_out_valid != tail.v)
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fma_arbiter.sv
// Randomized bench for fma_arbiter: model FMA plus a queue-based
// reference of grants, issues, responses, in_flight and err.
module tb_fma_arbiter;

  localparam int N  = 4;
  localparam int L  = 3;
  localparam int CW = $clog2(L+2);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*32-1:0]   req_a, req_b, req_c;
  logic [N*2-1:0]    req_op;
  logic              fma_in_valid;
  logic [31:0]       fma_a, fma_b, fma_c;
  logic [1:0]        fma_op;
  logic              fma_out_valid;
  logic [31:0]       fma_r;
  logic [N-1:0]      resp_valid;
  logic [31:0]       resp_r;
  logic [CW-1:0]     in_flight;
  logic              err;

  int total = 0;
  int bad   = 0;
  logic early = 1'b0;

  fma_arbiter #(.NUM_REQ(N), .FMA_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_op(req_op),
    .fma_in_valid(fma_in_valid),
    .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c), .fma_op(fma_op),
    .fma_out_valid(fma_out_valid), .fma_r(fma_r),
    .resp_valid(resp_valid), .resp_r(resp_r),
    .in_flight(in_flight), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fmaf(input logic [31:0] a,
                                       input logic [31:0] b,
                                       input logic [31:0] c,
                                       input logic [1:0]  op);
    longint pa, pb, p, cc, r;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    cc = longint'($signed(c));
    p  = (pa * pb) >>> 24;
    if (op[1]) p = -p;
    r = op[0] ? p - cc : p + cc;
    return r[31:0];
  endfunction

  // model FMA, sharing rst_n; "early" shortens its latency by one
  logic [L-1:0] fv;
  logic [31:0]  fr [L];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fv <= '0;
    end else begin
      fv    <= {fv[L-2:0], fma_in_valid};
      fr[0] <= fmaf(fma_a, fma_b, fma_c, fma_op);
      for (int k = 1; k < L; k++) fr[k] <= fr[k-1];
    end
  end
  assign fma_out_valid = early ? fv[L-2] : fv[L-1];
  assign fma_r         = early ? fr[L-2] : fr[L-1];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int          id;
    longint      due;
    logic [31:0] r;
  } ent_t;

  ent_t        q[$];
  int          m_ptr;
  logic        m_fiv, m_err;
  logic [31:0] m_a, m_b, m_c;
  logic [1:0]  m_op;
  longint      cyc = 0;
  int          n_resp2 = 0;
  int          n_any = 0;

  always @(negedge clk) begin
    int          w;
    int          j;
    logic        due_now;
    logic [N-1:0] e_rdy, e_resp;
    if (!rst_n) begin
      m_ptr = 0; m_fiv = 0; m_err = 0;
      m_a = 0; m_b = 0; m_c = 0; m_op = 0;
      q.delete();
    end
    w = -1;
    for (int k = 0; k < N; k++) begin
      j = (m_ptr + k) % N;
      if (w < 0 && req_valid[j]) w = j;
    end
    e_rdy = '0;
    if (w >= 0) e_rdy[w] = 1'b1;
    due_now = (q.size() > 0) && (q[0].due == cyc);
    e_resp = '0;
    if (fma_out_valid && due_now) e_resp[q[0].id] = 1'b1;

    chk("req_ready", 64'(req_ready), 64'(e_rdy));
    chk("fma_in_valid", 64'(fma_in_valid), 64'(m_fiv));
    chk("fma_a", 64'(fma_a), 64'(m_a));
    chk("fma_b", 64'(fma_b), 64'(m_b));
    chk("fma_c", 64'(fma_c), 64'(m_c));
    chk("fma_op", 64'(fma_op), 64'(m_op));
    chk("in_flight", 64'(in_flight), 64'(q.size()));
    chk("err", 64'(err), 64'(m_err));
    chk("resp_valid", 64'(resp_valid), 64'(e_resp));
    if (e_resp != 0) chk("resp_r", 64'(resp_r), 64'(q[0].r));

    if (resp_valid == 4'b0100) n_resp2++;
    if (resp_valid != 0) n_any++;

    if (rst_n) begin
      if (fma_out_valid != due_now) m_err = 1'b1;
      if (due_now) void'(q.pop_front());
      if (w >= 0) begin
        m_a   = req_a[32*w +: 32];
        m_b   = req_b[32*w +: 32];
        m_c   = req_c[32*w +: 32];
        m_op  = req_op[2*w +: 2];
        m_fiv = 1'b1;
        m_ptr = (w + 1) % N;
        q.push_back('{id: w, due: cyc + 1 + L,
                      r: fmaf(m_a, m_b, m_c, m_op)});
      end else begin
        m_fiv = 1'b0;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [1:0] op);
    req_valid[i]       = v;
    req_a[32*i +: 32]  = a;
    req_b[32*i +: 32]  = b;
    req_c[32*i +: 32]  = c;
    req_op[2*i +: 2]   = op;
  endtask

  task automatic rnd_ops();
    for (int i = 0; i < N; i++)
      set_req(i, req_valid[i], $urandom, $urandom, $urandom,
              2'($urandom_range(3, 0)));
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  int n_iss, r0, a0;

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0; req_b = '0; req_c = '0; req_op = '0;
    tick();
    @(negedge clk);
    chk("rst_fiv", 64'(fma_in_valid), 64'(0));
    chk("rst_inflight", 64'(in_flight), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    tick();
    rst_n = 1'b1;

    // single op, hand-computed: 1.0*2.0+0.5
    set_req(1, 1'b1, 32'h0100_0000, 32'h0200_0000, 32'h0080_0000, 2'd0);
    @(negedge clk);
    chk("t1_ready", 64'(req_ready), 64'(4'b0010));
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("t1_fiv", 64'(fma_in_valid), 64'(1));
    chk("t1_a", 64'(fma_a), 64'(32'h0100_0000));
    chk("t1_b", 64'(fma_b), 64'(32'h0200_0000));
    chk("t1_c", 64'(fma_c), 64'(32'h0080_0000));
    repeat (3) tick();
    @(negedge clk);
    chk("t1_resp", 64'(resp_valid), 64'(4'b0010));
    chk("t1_r", 64'(resp_r), 64'(32'h0280_0000));
    repeat (3) tick();

    // full contention from reset
    do_reset();
    req_valid = '1;
    rnd_ops();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("contend_grant", 64'(req_ready), 64'(1 << (k % 4)));
      tick();
      rnd_ops();
    end
    req_valid = '0;
    repeat (6) tick();

    // sparse rotation with ptr=2
    do_reset();
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b1011;
    @(negedge clk);
    chk("sparse_g3", 64'(req_ready), 64'(4'b1000));
    tick();
    req_valid = 4'b0011;
    @(negedge clk);
    chk("sparse_g0", 64'(req_ready), 64'(4'b0001));
    tick();
    req_valid = '0;
    repeat (6) tick();

    // streaming from requester 2
    n_iss = 0;
    r0 = n_resp2;
    req_valid = 4'b0100;
    for (int k = 0; k < 20; k++) begin
      rnd_ops();
      @(negedge clk);
      if (req_ready == 4'b0100) n_iss++;
      tick();
    end
    req_valid = '0;
    repeat (6) tick();
    chk("stream_issues", 64'(n_iss), 64'(20));
    chk("stream_resps", 64'(n_resp2 - r0), 64'(20));

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      req_valid = N'($urandom);
      rnd_ops();
      tick();
    end
    req_valid = '0;
    repeat (6) tick();

    // reset with three operations in flight
    req_valid = 4'b0001;
    repeat (3) begin
      rnd_ops();
      tick();
    end
    req_valid = '0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    a0 = n_any;
    @(negedge clk);
    chk("mid_rst_err", 64'(err), 64'(0));
    chk("mid_rst_inflight", 64'(in_flight), 64'(0));
    chk("mid_rst_fiv", 64'(fma_in_valid), 64'(0));
    repeat (6) tick();
    chk("mid_rst_noresp", 64'(n_any - a0), 64'(0));

    // FMA result arrives one cycle early
    early = 1'b1;
    a0 = n_any;
    req_valid = 4'b1000;
    rnd_ops();
    tick();
    req_valid = '0;
    repeat (6) tick();
    early = 1'b0;
    @(negedge clk);
    chk("desync_err", 64'(err), 64'(1));
    chk("desync_noresp", 64'(n_any - a0), 64'(0));
    tick();
    req_valid = 4'b0001;
    rnd_ops();
    tick();
    req_valid = '0;
    repeat (6) tick();
    chk("desync_sticky", 64'(err), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
